// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the PC sequencer: FSM state encoding,
// sequential PC increment and default reset/trap vectors.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        STALL = 2'd2,
        FLUSH = 2'd3
    } state_t;

    localparam int          PC_INCR              = 4;
    localparam logic [63:0] DEFAULT_RESET_VECTOR = 64'h0;
    localparam logic [63:0] DEFAULT_TRAP_VECTOR  = 64'h100;

    function automatic logic misaligned(input logic [1:0] low_bits);
        return low_bits != 2'b00;
    endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter register: async active-low reset to RESET_VECTOR,
// loads next_pc whenever load is high.
module pc_reg #(
    parameter int              XLEN         = 64,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic [XLEN-1:0] next_pc,
    output logic [XLEN-1:0] pc
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc <= RESET_VECTOR;
        end else if (load) begin
            pc <= next_pc;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Instruction-fetch PC sequencer: BOOT/FETCH/STALL/FLUSH FSM plus next-PC mux.
// Define PC_MISALIGN_CHECK_EN to add the trap port and misaligned-redirect trapping.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int              XLEN         = 64,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEFAULT_RESET_VECTOR),
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(DEFAULT_TRAP_VECTOR)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    output logic            if_valid,
    output logic [XLEN-1:0] if_pc
`ifdef PC_MISALIGN_CHECK_EN
    ,
    output logic            trap
`endif
);

`ifdef PC_MISALIGN_CHECK_EN
    localparam logic CHECK_EN = 1'b1;
`else
    localparam logic CHECK_EN = 1'b0;
`endif

    state_t          state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_seq;
    logic [XLEN-1:0] pc_next;
    logic [XLEN-1:0] redirect_dest;
    logic [XLEN-1:0] flush_target;
    logic            redirect_bad;
    logic            pc_load;

    pc_reg #(
        .XLEN         (XLEN),
        .RESET_VECTOR (RESET_VECTOR)
    ) u_pc_reg (
        .clk     (clk),
        .reset   (reset),
        .load    (pc_load),
        .next_pc (pc_next),
        .pc      (pc)
    );

    assign imem_addr = pc;

    // Next-PC selection; the PC only moves once the outstanding fetch has been acked.
    always_comb begin
        redirect_bad  = CHECK_EN && misaligned(redirect_target[1:0]);
        redirect_dest = redirect_bad ? TRAP_VECTOR : redirect_target;
        pc_seq        = pc + XLEN'(PC_INCR);
        pc_load       = 1'b0;
        pc_next       = pc;
        case (state)
            BOOT: begin
                if (redirect_valid) begin
                    pc_load = 1'b1;
                    pc_next = redirect_dest;
                end
            end
            FETCH: begin
                if (imem_ack) begin
                    if (redirect_valid) begin
                        pc_load = 1'b1;
                        pc_next = redirect_dest;
                    end else if (!stall) begin
                        pc_load = 1'b1;
                        pc_next = pc_seq;
                    end
                end
            end
            STALL: begin
                if (redirect_valid) begin
                    pc_load = 1'b1;
                    pc_next = redirect_dest;
                end else if (!stall) begin
                    pc_load = 1'b1;
                    pc_next = pc_seq;
                end
            end
            FLUSH: begin
                if (imem_ack) begin
                    pc_load = 1'b1;
                    pc_next = redirect_valid ? redirect_dest : flush_target;
                end
            end
            default: begin
                pc_load = 1'b0;
                pc_next = pc;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= BOOT;
            imem_req     <= 1'b0;
            if_valid     <= 1'b0;
            if_pc        <= '0;
            flush_target <= '0;
`ifdef PC_MISALIGN_CHECK_EN
            trap         <= 1'b0;
`endif
        end else begin
`ifdef PC_MISALIGN_CHECK_EN
            trap <= redirect_valid && redirect_bad;
`endif
            case (state)
                BOOT: begin
                    state    <= FETCH;
                    imem_req <= 1'b1;
                    if_valid <= 1'b0;
                end
                FETCH: begin
                    if (imem_ack) begin
                        if (redirect_valid) begin
                            if_valid <= 1'b0;
                        end else if (stall) begin
                            state    <= STALL;
                            imem_req <= 1'b0;
                            if_valid <= 1'b1;
                            if_pc    <= pc;
                        end else begin
                            if_valid <= 1'b1;
                            if_pc    <= pc;
                        end
                    end else begin
                        if_valid <= 1'b0;
                        if (redirect_valid) begin
                            state        <= FLUSH;
                            flush_target <= redirect_dest;
                        end
                    end
                end
                STALL: begin
                    if (redirect_valid || !stall) begin
                        state    <= FETCH;
                        imem_req <= 1'b1;
                        if_valid <= 1'b0;
                    end
                end
                FLUSH: begin
                    // The instruction returned here belongs to the abandoned path.
                    if_valid <= 1'b0;
                    if (imem_ack) begin
                        state <= FETCH;
                    end else if (redirect_valid) begin
                        flush_target <= redirect_dest;
                    end
                end
                default: begin
                    state    <= BOOT;
                    imem_req <= 1'b0;
                    if_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus random traffic
// compared cycle by cycle against a behavioural fetch model.
module tb_pc_sequencer;

    logic        clk             = 1'b0;
    logic        reset           = 1'b1;
    logic        stall           = 1'b0;
    logic        redirect_valid  = 1'b0;
    logic [63:0] redirect_target = '0;
    logic        imem_ack        = 1'b0;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        if_valid;
    logic [63:0] if_pc;
`ifdef PC_MISALIGN_CHECK_EN
    logic        trap;
`endif

    int checks = 0;
    int errors = 0;

    pc_sequencer dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .if_valid        (if_valid),
        .if_pc           (if_pc)
`ifdef PC_MISALIGN_CHECK_EN
        ,
        .trap            (trap)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: booting / holding a delivered instruction / fetching,
    // with a pending-discard flag for a redirect that arrived before its ack.
    bit          m_boot, m_hold, m_discard, m_req, m_valid, m_trap;
    logic [63:0] m_pc, m_if_pc, m_pending;

    function automatic void model_reset();
        m_boot = 1; m_hold = 0; m_discard = 0; m_req = 0; m_valid = 0; m_trap = 0;
        m_pc = 64'h0; m_if_pc = 64'h0; m_pending = 64'h0;
    endfunction

    function automatic logic [63:0] dest_of(input logic [63:0] t);
`ifdef PC_MISALIGN_CHECK_EN
        if (t[1:0] != 2'b00) return 64'h100;
`endif
        return t;
    endfunction

    function automatic void model_step();
        logic [63:0] d;
        d = dest_of(redirect_target);
        m_trap = 0;
`ifdef PC_MISALIGN_CHECK_EN
        m_trap = redirect_valid && (redirect_target[1:0] != 2'b00);
`endif
        if (m_boot) begin
            m_boot = 0;
            m_valid = 0;
            if (redirect_valid) m_pc = d;
        end else if (m_hold) begin
            if (redirect_valid) begin
                m_pc = d; m_hold = 0; m_valid = 0;
            end else if (!stall) begin
                m_pc = m_pc + 64'd4; m_hold = 0; m_valid = 0;
            end
        end else if (imem_ack) begin
            if (m_discard) begin
                m_pc = redirect_valid ? d : m_pending;
                m_discard = 0;
                m_valid = 0;
            end else if (redirect_valid) begin
                m_pc = d;
                m_valid = 0;
            end else begin
                m_valid = 1;
                m_if_pc = m_pc;
                if (stall) m_hold = 1;
                else m_pc = m_pc + 64'd4;
            end
        end else begin
            m_valid = 0;
            if (redirect_valid) begin
                m_discard = 1;
                m_pending = d;
            end
        end
        m_req = !m_boot && !m_hold;
    endfunction

    task automatic drive_cycle(input bit s, input bit rv, input logic [63:0] rt, input bit ack);
        stall = s; redirect_valid = rv; redirect_target = rt; imem_ack = ack;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        #1 reset = 1'b0;
        model_reset();
        #2;
        checks++;
        if ({imem_req, imem_addr, if_valid, if_pc} !== {1'b0, 64'h0, 1'b0, 64'h0}) begin
            errors++;
            $display("[TB] FAIL reset: got req=%0b addr=%h valid=%0b if_pc=%h, expected all zero",
                     imem_req, imem_addr, if_valid, if_pc);
        end
        @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic test_sequential();
        for (int k = 1; k <= 3; k++) begin
            drive_cycle(0, 0, 64'h0, 1);
            checks++;
            if ({imem_req, imem_addr, if_valid, if_pc} !== {m_req, m_pc, m_valid, m_if_pc}) begin
                errors++;
                $display("[TB] FAIL seq_model: got req=%0b addr=%h valid=%0b if_pc=%h, expected req=%0b addr=%h valid=%0b if_pc=%h",
                         imem_req, imem_addr, if_valid, if_pc, m_req, m_pc, m_valid, m_if_pc);
            end
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== 64'(4 * (k - 1))
                || if_valid !== (k > 1) || (k > 1 && if_pc !== 64'(4 * (k - 2)))) begin
                errors++;
                $display("[TB] FAIL seq_addr: cycle %0d got req=%0b addr=%h valid=%0b if_pc=%h", k,
                         imem_req, imem_addr, if_valid, if_pc);
            end
        end
    endtask

    task automatic test_stall();
        for (int k = 0; k < 4; k++) begin
            drive_cycle(k < 3, 0, 64'h0, k == 0);
            checks++;
            if ({imem_req, imem_addr, if_valid, if_pc} !== {m_req, m_pc, m_valid, m_if_pc}) begin
                errors++;
                $display("[TB] FAIL stall_model: got req=%0b addr=%h valid=%0b if_pc=%h, expected req=%0b addr=%h valid=%0b if_pc=%h",
                         imem_req, imem_addr, if_valid, if_pc, m_req, m_pc, m_valid, m_if_pc);
            end
            checks++;
            if (k < 3 ? (if_valid !== 1'b1 || if_pc !== 64'h8 || imem_req !== 1'b0)
                      : (if_valid !== 1'b0 || imem_addr !== 64'hC || imem_req !== 1'b1)) begin
                errors++;
                $display("[TB] FAIL stall_hold: cycle %0d got req=%0b addr=%h valid=%0b if_pc=%h", k,
                         imem_req, imem_addr, if_valid, if_pc);
            end
        end
    endtask

    task automatic test_flush();
        drive_cycle(0, 0, 64'h0, 1);
        drive_cycle(0, 1, 64'h400, 0);
        drive_cycle(0, 0, 64'h0, 0);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 64'h10 || if_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL flush_hold: got req=%0b addr=%h valid=%0b, expected req=1 addr=10 valid=0",
                     imem_req, imem_addr, if_valid);
        end
        drive_cycle(0, 0, 64'h0, 1);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 64'h400 || if_valid !== 1'b0
            || {imem_addr, if_pc} !== {m_pc, m_if_pc}) begin
            errors++;
            $display("[TB] FAIL flush_target: got req=%0b addr=%h valid=%0b if_pc=%h, expected addr=400 valid=0 if_pc=%h",
                     imem_req, imem_addr, if_valid, if_pc, m_if_pc);
        end
    endtask

    task automatic test_redirect_stall();
        drive_cycle(0, 0, 64'h0, 1);
        drive_cycle(1, 0, 64'h0, 1);
        drive_cycle(1, 1, 64'h200, 0);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 64'h200 || if_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL redir_in_stall: got req=%0b addr=%h valid=%0b, expected req=1 addr=200 valid=0",
                     imem_req, imem_addr, if_valid);
        end
        drive_cycle(1, 1, 64'h300, 1);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 64'h300 || if_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL redir_at_ack: got req=%0b addr=%h valid=%0b, expected req=1 addr=300 valid=0",
                     imem_req, imem_addr, if_valid);
        end
    endtask

    task automatic test_misalign();
        drive_cycle(0, 1, 64'h202, 1);
        checks++;
`ifdef PC_MISALIGN_CHECK_EN
        if (trap !== 1'b1 || imem_addr !== 64'h100) begin
            errors++;
            $display("[TB] FAIL misalign: got trap=%0b addr=%h, expected trap=1 addr=100", trap, imem_addr);
        end
        drive_cycle(0, 0, 64'h0, 0);
        checks++;
        if (trap !== 1'b0) begin
            errors++;
            $display("[TB] FAIL trap_pulse: got trap=%0b, expected 0", trap);
        end
`else
        if (imem_addr !== 64'h202 || if_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL misalign: got addr=%h valid=%0b, expected addr=202 valid=0", imem_addr, if_valid);
        end
        drive_cycle(0, 0, 64'h0, 0);
`endif
    endtask

    task automatic test_wrap();
        drive_cycle(0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 1);
        drive_cycle(0, 0, 64'h0, 1);
        checks++;
        if (imem_addr !== 64'h0 || if_valid !== 1'b1 || if_pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin
            errors++;
            $display("[TB] FAIL wrap: got addr=%h valid=%0b if_pc=%h, expected addr=0 valid=1 if_pc=fffffffffffffffc",
                     imem_addr, if_valid, if_pc);
        end
        drive_cycle(0, 0, 64'h0, 1);
    endtask

    task automatic test_reset_mid_request();
        imem_ack = 1'b0;
        #3 reset = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({imem_req, imem_addr, if_valid, if_pc} !== {1'b0, 64'h0, 1'b0, 64'h0}) begin
            errors++;
            $display("[TB] FAIL reset_async: got req=%0b addr=%h valid=%0b if_pc=%h, expected all zero",
                     imem_req, imem_addr, if_valid, if_pc);
        end
        imem_ack = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({imem_req, imem_addr, if_valid, if_pc} !== {1'b0, 64'h0, 1'b0, 64'h0}) begin
            errors++;
            $display("[TB] FAIL reset_ack_ignored: got req=%0b addr=%h valid=%0b if_pc=%h, expected all zero",
                     imem_req, imem_addr, if_valid, if_pc);
        end
        reset = 1'b1;
        drive_cycle(0, 0, 64'h0, 1);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 64'h0 || if_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_boot: got req=%0b addr=%h valid=%0b, expected req=1 addr=0 valid=0",
                     imem_req, imem_addr, if_valid);
        end
        drive_cycle(0, 0, 64'h0, 1);
        checks++;
        if ({imem_req, imem_addr, if_valid, if_pc} !== {1'b1, 64'h4, 1'b1, 64'h0}) begin
            errors++;
            $display("[TB] FAIL reset_first_fetch: got req=%0b addr=%h valid=%0b if_pc=%h, expected req=1 addr=4 valid=1 if_pc=0",
                     imem_req, imem_addr, if_valid, if_pc);
        end
    endtask

    task automatic test_random();
        logic [63:0] tgt;
        for (int n = 0; n < 400; n++) begin
            tgt = {$urandom, $urandom};
            if ($urandom_range(3) != 0) tgt[1:0] = 2'b00;
            drive_cycle($urandom_range(9) < 3, $urandom_range(9) == 0, tgt, $urandom_range(9) < 6);
            checks++;
            if ({imem_req, imem_addr, if_valid, if_pc} !== {m_req, m_pc, m_valid, m_if_pc}) begin
                errors++;
                $display("[TB] FAIL random: cycle %0d got req=%0b addr=%h valid=%0b if_pc=%h, expected req=%0b addr=%h valid=%0b if_pc=%h",
                         n, imem_req, imem_addr, if_valid, if_pc, m_req, m_pc, m_valid, m_if_pc);
            end
`ifdef PC_MISALIGN_CHECK_EN
            checks++;
            if (trap !== m_trap) begin
                errors++;
                $display("[TB] FAIL random_trap: cycle %0d got trap=%0b, expected %0b", n, trap, m_trap);
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_flush();
        test_redirect_stall();
        test_misalign();
        test_wrap();
        test_reset_mid_request();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter XLEN, default 64, PC/address width in bits.
REQ-002 SHALL have parameter RESET_VECTOR, default 64'h0, PC value loaded on reset.
REQ-003 SHALL have parameter TRAP_VECTOR, default 64'h100, PC loaded on a misaligned redirect.
REQ-004 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-low reset: 0 = reset.
REQ-006 SHALL have port stall, input, 1, downstream hazard: hold the delivered instruction and issue no new fetch.
REQ-007 SHALL have port redirect_valid, input, 1, one-cycle branch/jump redirect strobe.
REQ-008 SHALL have port redirect_target, input, XLEN, redirect destination; sampled only when redirect_valid=1.
REQ-009 SHALL have port imem_req, output, 1, fetch request to instruction memory.
REQ-010 SHALL have port imem_addr, output, XLEN, fetch address; equals the current PC.
REQ-011 SHALL have port imem_ack, input, 1, memory accepts or completes the fetch in the same cycle.
REQ-012 SHALL have port if_valid, output, 1, fetched instruction valid for the decode stage.
REQ-013 SHALL have port if_pc, output, XLEN, PC of the instruction flagged by if_valid.
REQ-014 SHALL have port trap, output, 1, one-cycle misaligned-redirect flag; present only with the macro.

Function
REQ-015 SHALL implement states BOOT, FETCH, STALL, FLUSH.
REQ-016 BOOT SHALL drive imem_req=0 for one cycle, then go to FETCH.
REQ-017 FETCH SHALL assert imem_req=1 with imem_addr=PC, and SHALL keep both stable until imem_ack=1.
REQ-018 In FETCH, on imem_ack=1 with stall=0 and no redirect, the block SHALL pulse if_valid=1 and set if_pc=PC on the next cycle, then set PC=PC+4, modulo 2^XLEN wrap.
REQ-019 On imem_ack=1 with stall=1, the block SHALL deliver the instruction, enter STALL, and hold if_valid=1 and if_pc stable.
REQ-020 STALL SHALL drive imem_req=0 and SHALL hold PC; when stall falls, if_valid SHALL drop and FETCH SHALL resume at PC+4.
REQ-021 A redirect while a request is outstanding with no ack SHALL enter FLUSH, latch the target, and keep imem_req asserted until ack.
REQ-022 In FLUSH, the acked instruction SHALL be discarded (if_valid=0); the block SHALL then load PC=target and go to FETCH.
REQ-023 A redirect in the ack cycle SHALL discard that instruction and load PC=target next cycle.
REQ-024 A redirect in BOOT or STALL SHALL load PC=target next cycle, clear if_valid, and go to FETCH.
REQ-025 Priority SHALL be: reset > trap > redirect > stall > sequential advance.
REQ-026 A redirect SHALL override stall.
REQ-027 When PC reaches 2^XLEN-4, sequential advance SHALL wrap PC to 0 with no flag.

Reset
REQ-028 While reset=0, the block SHALL asynchronously force state=BOOT, PC=RESET_VECTOR, imem_req=0, if_valid=0, if_pc=0, trap=0, and clear any latched target.
REQ-029 Reset asserted mid-request SHALL abandon the request; the block SHALL ignore an ack arriving after reset.

Configuration
REQ-030 Macro PC_MISALIGN_CHECK_EN SHALL gate the misalignment check.
REQ-031 With PC_MISALIGN_CHECK_EN defined, a redirect with redirect_target[1:0]!=0 SHALL pulse trap=1 for one cycle and load PC=TRAP_VECTOR in place of the target.
REQ-032 Without PC_MISALIGN_CHECK_EN, the trap port SHALL be absent and redirect_target SHALL be loaded unchanged.

Structure
REQ-033 Shared package pc_seq_pkg SHALL hold the state enum type, the PC increment constant 4, and the default vectors.
REQ-034 PC register SHALL be one sub-module, pc_reg, with async active-low reset, load enable, and next-value input; FSM and next-PC mux SHALL reside in pc_sequencer.

Verification
REQ-035 Release reset, ack every cycle -> imem_addr sequence 0x0, 0x4, 0x8; if_pc follows one cycle later.
REQ-036 Stall=1 for 3 cycles at an ack of 0x8 -> if_valid and if_pc=0x8 held 3 cycles, imem_req=0; next fetch 0xC.
REQ-037 Redirect to 0x400 while 0x10 is outstanding, ack delayed 2 cycles -> FLUSH; 0x10 discarded; next imem_addr=0x400.
REQ-038 Redirect to 0x200 and stall=1 in the same cycle -> PC=0x200, if_valid=0, fetch 0x200.
REQ-039 With macro, redirect to 0x202 -> trap pulse 1 cycle, next imem_addr=0x100; without macro, 0x202.
REQ-040 Assert reset with a request outstanding, ack during reset -> outputs at reset values, first fetch RESET_VECTOR after BOOT.
